sequence_generator: RTL
=======================

Name: sequence_generator

Overview:
Serial pattern transmitter: the source side of the serial-bit sequence detector interface.
- Captures a PAT_W-bit pattern and a repeat count, then drives the pattern MSB-first on a 1-bit serial output, one bit per clock.
- Drives the `x` input of the detector in loopback benches and in the integrated datapath.
- Start/ready handshake, done pulse, synchronous abort.

Parameters:
- PAT_W, 4, pattern width in bits (>= 2).
- CNT_W, 4, repeat-count width.
- IDLE_LVL, 0, level driven on `x` when not transmitting.
- GAP_CYC, 2, idle cycles inserted between repetitions (used only with GAP_EN).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when ready=1.
- pattern  input  PAT_W  bits to send, MSB first; sampled at accept.
- repeat_cnt  input  CNT_W  number of back-to-back repetitions; 0 is treated as 1; sampled at accept.
- abort  input  1  synchronous cancel of an active transmission.
- x  output  1  serial data, registered.
- ready  output  1  high in IDLE.
- busy  output  1  high while transmitting or in a gap.
- done  output  1  one-cycle pulse after the last bit of the last repetition.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, x=IDLE_LVL, ready=1, busy=0, done=0; shift and repeat registers cleared. Reset mid-transmission aborts immediately with no done pulse.
- States: IDLE, SHIFT, GAP (GAP exists only with GAP_EN).
- IDLE:
  - On an edge with start=1, capture pattern and max(repeat_cnt,1), move to SHIFT.
  - In the cycle after that edge, x=pattern[PAT_W-1], ready=0, busy=1.
- SHIFT:
  - x advances one bit per clock, MSB to LSB; each bit is held exactly one cycle.
  - After the LSB cycle:
    - If repetitions remain, decrement the count and reload from the captured copy. The next cycle drives the MSB again with no idle cycle, so 0101 repeated gives a contiguous 01010101 stream.
    - Otherwise return to IDLE: x=IDLE_LVL, busy=0, ready=1, done=1 for exactly that one cycle.
- Latency: accept edge to first bit = 1 cycle. Total busy cycles = PAT_W*N (N = effective repeat count).
- Simultaneous events:
  - start while busy=1 is ignored; pattern and repeat_cnt changes while busy have no effect.
  - start in the same cycle done=1 is accepted, since ready=1 then. The next pattern begins the following cycle.
  - abort=1 while busy: next cycle is IDLE, x=IDLE_LVL, no done pulse.
  - abort has priority over start and over the repeat reload.
  - abort in IDLE has no effect.
- Counters: the bit index is log2-sized and wraps at PAT_W-1. The repeat counter never underflows; max repetitions = 2^CNT_W-1.

Optional Feature:
- Macro GAP_EN.
- Defined:
  - Between consecutive repetitions the FSM enters GAP for GAP_CYC cycles, driving x=IDLE_LVL with busy=1.
  - abort is honoured in GAP.
  - Total busy = PAT_W*N + GAP_CYC*(N-1).
  - No gap after the last repetition.
- Undefined: GAP state and logic are absent; repetitions are contiguous.

Test Plan:
1. Reset then idle
   - Stimulus: rst_n=0 for 2 cycles, release.
   - Response: x=0, ready=1, busy=0, done=0. Assert rst_n=0 mid-SHIFT: x=0, ready=1 asynchronously, no done.
2. Single pattern
   - Stimulus: pattern=4'b0101, repeat_cnt=1, start for one cycle.
   - Response: x=0,1,0,1 on cycles 1-4; done=1 on cycle 5; busy high cycles 1-4.
3. Repeats, including zero count
   - Stimulus: pattern=4'b0110, repeat_cnt=3.
   - Response: x=011001100110 over 12 contiguous cycles; done on cycle 13. With repeat_cnt=0: identical to repeat_cnt=1.
4. Handshake
   - Stimulus: start with 4'b0101, pattern changed to 4'b1111 with start held during busy; then start re-asserted on the done cycle with 4'b0011.
   - Response: first stream stays 0101; 0011 begins the cycle after done.
5. Abort
   - Stimulus: start 4'b0101, repeat_cnt=2; abort on cycle 3.
   - Response: cycle 4 x=0, ready=1, busy=0; done never asserts.
6. GAP_EN (GAP_CYC=2)
   - Stimulus: pattern=4'b0101, repeat_cnt=2.
   - Response: x=0101,0,0,0101; busy for 10 cycles; done on cycle 11.

Source files
------------

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a captured PAT_W-bit pattern MSB-first, N times.
// Define GAP_EN to insert GAP_CYC idle cycles between consecutive repetitions.
module sequence_generator #(
   parameter int PAT_W    = 4,
   parameter int CNT_W    = 4,
   parameter bit IDLE_LVL = 1'b0,
   parameter int GAP_CYC  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic             abort,
   output logic             x,
   output logic             ready,
   output logic             busy,
   output logic             done
);

   localparam int IDX_W = $clog2(PAT_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

`ifdef GAP_EN
   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   logic [GAP_W-1:0] gap_q, gap_d;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t           state_q, state_d;
   logic [PAT_W-1:0] shift_q, shift_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] rep_q, rep_d;
   logic             x_q, x_d;
   logic             done_q, done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         pat_q   <= '0;
         idx_q   <= '0;
         rep_q   <= '0;
         x_q     <= IDLE_LVL;
         done_q  <= 1'b0;
`ifdef GAP_EN
         gap_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         pat_q   <= pat_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
         x_q     <= x_d;
         done_q  <= done_d;
`ifdef GAP_EN
         gap_q   <= gap_d;
`endif
      end
   end

   // shift_q holds the bits still to be sent after the one currently on x
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      pat_d   = pat_q;
      idx_d   = idx_q;
      rep_d   = rep_q;
      x_d     = x_q;
      done_d  = 1'b0;
`ifdef GAP_EN
      gap_d   = gap_q;
`endif
      unique case (state_q)
         IDLE: begin
            x_d = IDLE_LVL;
            if (start) begin
               state_d = SHIFT;
               pat_d   = pattern;
               shift_d = pattern << 1;
               x_d     = pattern[PAT_W-1];
               idx_d   = '0;
               rep_d   = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_d = IDLE;
               x_d     = IDLE_LVL;
            end else if (idx_q != LAST_IDX) begin
               x_d     = shift_q[PAT_W-1];
               shift_d = shift_q << 1;
               idx_d   = idx_q + 1'b1;
            end else if (rep_q > CNT_W'(1)) begin
               rep_d = rep_q - 1'b1;
               idx_d = '0;
`ifdef GAP_EN
               state_d = GAP;
               x_d     = IDLE_LVL;
               gap_d   = GAP_W'(GAP_CYC - 1);
`else
               x_d     = pat_q[PAT_W-1];
               shift_d = pat_q << 1;
`endif
            end else begin
               state_d = IDLE;
               x_d     = IDLE_LVL;
               done_d  = 1'b1;
            end
         end
`ifdef GAP_EN
         GAP: begin
            if (abort) begin
               state_d = IDLE;
               x_d     = IDLE_LVL;
            end else if (gap_q == '0) begin
               state_d = SHIFT;
               x_d     = pat_q[PAT_W-1];
               shift_d = pat_q << 1;
               idx_d   = '0;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
`endif
         default: begin
            state_d = IDLE;
            x_d     = IDLE_LVL;
         end
      endcase
   end

   assign x     = x_q;
   assign done  = done_q;
   assign ready = (state_q == IDLE);
   assign busy  = (state_q != IDLE);

endmodule
